// File: rtl/truth_table_sweeper_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// lab_sweep_pkg : shared state encoding and default sizing for the
//                 truth_table_sweeper.                    Rev 1.0
// ------------------------------------------------------------------
package lab_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } sweep_state_t;

   localparam int c_DEF_N_IN  = 4;
   localparam int c_DEF_N_OUT = 1;
   localparam int c_DEF_DWELL = 10;

endpackage
`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// ------------------------------------------------------------------
// truth_table_sweeper_if : control, vector and response bundle between
//                          the sweeper (master) and the lab side.  Rev 1.0
// ------------------------------------------------------------------
interface truth_table_sweeper_if
   import lab_sweep_pkg::*;
#(
   parameter int N_IN  = c_DEF_N_IN,
   parameter int N_OUT = c_DEF_N_OUT
);
   logic                      start;
   logic                      abort;
   logic [N_OUT-1:0]          resp_i;
   logic [N_IN-1:0]           vec_o;
   logic [N_IN-1:0]           idx_o;
   logic                      busy;
   logic                      done;
   logic [(N_OUT<<N_IN)-1:0]  table_o;

   modport master (
      input  start, abort, resp_i,
      output vec_o, idx_o, busy, done, table_o
   );

   modport slave (
      output start, abort, resp_i,
      input  vec_o, idx_o, busy, done, table_o
   );
endinterface
`default_nettype wire

// File: rtl/truth_table_sweeper_dwell_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// dwell_timer : counts 0..DWELL-1 while enabled; last flags the sample
//               cycle of the current vector.               Rev 1.0
// ------------------------------------------------------------------
module dwell_timer #(
   parameter int DWELL = 10
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic clr,
   input  wire logic en,
   output logic      last
);
   localparam int             c_W    = $clog2(DWELL + 1);
   localparam logic [c_W-1:0] c_LAST = c_W'(DWELL - 1);

   logic [c_W-1:0] r_cnt;

   assign last = (r_cnt == c_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= last ? '0 : r_cnt + 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ------------------------------------------------------------------
// truth_table_sweeper : drives every input vector in ascending order
//                       and records the UUT response per vector. Rev 1.0
// ------------------------------------------------------------------
module truth_table_sweeper
   import lab_sweep_pkg::*;
#(
   parameter int N_IN  = c_DEF_N_IN,
   parameter int N_OUT = c_DEF_N_OUT,
   parameter int DWELL = c_DEF_DWELL
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   truth_table_sweeper_if.master   bus
);
   localparam logic [N_IN-1:0] c_VEC_LAST = '1;

   sweep_state_t               r_state;
   logic [N_IN-1:0]            r_vec;
   logic                       r_busy;
   logic                       r_done;
   logic [(N_OUT<<N_IN)-1:0]   r_table;

   logic w_last;
   logic w_tmr_en;
   logic w_tmr_clr;

   // Timer only runs in SWEEP; an abort restarts it so the next sweep begins at dwell 0.
   assign w_tmr_en  = (r_state == SWEEP);
   assign w_tmr_clr = (r_state != SWEEP) | bus.abort;

   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_tmr_clr),
      .en    (w_tmr_en),
      .last  (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_vec   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_table <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  r_state <= SWEEP;
                  r_busy  <= 1'b1;
                  r_vec   <= '0;
                  r_table <= '0;
               end
            end
            SWEEP: begin
               if (bus.abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_vec   <= '0;
               end else if (w_last) begin
                  r_table[int'(r_vec)*N_OUT +: N_OUT] <= bus.resp_i;
                  // The counter parks at all-ones; the sweep ends instead of wrapping.
                  if (r_vec == c_VEC_LAST) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_vec <= r_vec + 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_vec   <= '0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.vec_o   = r_vec;
   assign bus.idx_o   = r_vec;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.table_o = r_table;
endmodule
`default_nettype wire
